// File: rtl/uart_sdram_cmd_parser.sv
// Purpose : parse framed, XOR-checksummed UART byte streams into SDRAM write/read burst requests.
// Latency : all outputs registered, 1 clk after the causing rx_done (or after sdram_busy first sampled low).
// Backpr. : sdram_busy parks a good frame in PEND; bytes arriving meanwhile are dropped and counted.
// Ports   : clk/rst (sync, active-high); rx_done/uart_data byte strobe in; sdram_busy trigger hold-off;
//           wr_trig/rd_trig + cmd_addr/cmd_len burst request; wfifo_wr_en/wfifo_data/wfifo_clr write FIFO;
//           frame_err/err_code error report (1 hdr/len, 2 csum, 3 timeout); drop_cnt saturating drop count.
module uart_sdram_cmd_parser #(
  parameter int         ADDR_BYTES  = 3,
  parameter int         ADDR_W      = 22,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] CMD_WR      = 8'h55,
  parameter logic [7:0] CMD_RD      = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        uart_data,
  input  logic              sdram_busy,
  output logic              wr_trig,
  output logic              rd_trig,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              wfifo_wr_en,
  output logic [7:0]        wfifo_data,
  output logic              wfifo_clr,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        drop_cnt
);

  localparam int              TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]      ADDR_LAST = 8'(ADDR_BYTES - 1);
  localparam logic [1:0]      ERR_FMT   = 2'd1;
  localparam logic [1:0]      ERR_CSUM  = 2'd2;
  localparam logic [1:0]      ERR_TO    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_PEND
  } state_t;

  state_t state_q, state_d;

  // frame context
  logic              is_wr_q, is_wr_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              pushed_q, pushed_d;

  // registered outputs
  logic              wr_trig_q, wr_trig_d;
  logic              rd_trig_q, rd_trig_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic              wfifo_wr_en_q, wfifo_wr_en_d;
  logic [7:0]        wfifo_data_q, wfifo_data_d;
  logic              wfifo_clr_q, wfifo_clr_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  // decoded per-cycle events
  logic in_frame, timeout_hit, is_hdr, len_bad, csum_ok, addr_last, data_last;

  assign in_frame    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
  // a byte landing on the expiry cycle is processed instead of timing out
  assign timeout_hit = in_frame && !rx_done && (to_cnt_q == TO_LAST);
  assign is_hdr      = (uart_data == CMD_WR) || (uart_data == CMD_RD);
  assign len_bad     = (uart_data == 8'd0) || (uart_data > MAX_LEN_B);
  assign csum_ok     = (uart_data == csum_q);
  assign addr_last   = (byte_cnt_q == ADDR_LAST);
  assign data_last   = (byte_cnt_q == len_q - 8'd1);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (rx_done && is_hdr)    state_d = S_ADDR;
        S_ADDR: if (rx_done && addr_last) state_d = S_LEN;
        S_LEN:  if (rx_done)              state_d = len_bad ? S_IDLE : (is_wr_q ? S_DATA : S_CSUM);
        S_DATA: if (rx_done && data_last) state_d = S_CSUM;
        S_CSUM: if (rx_done)              state_d = (csum_ok && sdram_busy) ? S_PEND : S_IDLE;
        S_PEND: if (!sdram_busy)          state_d = S_IDLE;
        default:                          state_d = S_IDLE;
      endcase
    end
  end

  // datapath and output strobes
  always_comb begin
    is_wr_d       = is_wr_q;
    csum_d        = csum_q;
    addr_d        = addr_q;
    len_d         = len_q;
    byte_cnt_d    = byte_cnt_q;
    pushed_d      = pushed_q;
    to_cnt_d      = (rx_done || !in_frame) ? '0 : to_cnt_q + 1'b1;
    wr_trig_d     = 1'b0;
    rd_trig_d     = 1'b0;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    wfifo_wr_en_d = 1'b0;
    wfifo_data_d  = wfifo_data_q;
    wfifo_clr_d   = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    drop_cnt_d    = drop_cnt_q;

    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TO;
      wfifo_clr_d = pushed_q;  // only flush if this frame already put bytes in the FIFO
      to_cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_done) begin
            if (is_hdr) begin
              is_wr_d    = (uart_data == CMD_WR);
              csum_d     = uart_data;
              byte_cnt_d = 8'd0;
              pushed_d   = 1'b0;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_FMT;
            end
          end
        end
        S_ADDR: begin
          if (rx_done) begin
            // MSB-first shift; bytes above ADDR_W simply fall off the top
            addr_d     = ADDR_W'({addr_q, uart_data});
            csum_d     = csum_q ^ uart_data;
            byte_cnt_d = addr_last ? 8'd0 : byte_cnt_q + 8'd1;
          end
        end
        S_LEN: begin
          if (rx_done) begin
            csum_d = csum_q ^ uart_data;
            len_d  = uart_data;
            if (len_bad) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_FMT;
            end
          end
        end
        S_DATA: begin
          if (rx_done) begin
            csum_d        = csum_q ^ uart_data;
            byte_cnt_d    = byte_cnt_q + 8'd1;
            wfifo_wr_en_d = 1'b1;
            wfifo_data_d  = uart_data;
            pushed_d      = 1'b1;
          end
        end
        S_CSUM: begin
          if (rx_done) begin
            if (csum_ok) begin
              cmd_addr_d = addr_q;
              cmd_len_d  = len_q;
              if (!sdram_busy) begin
                wr_trig_d = is_wr_q;
                rd_trig_d = !is_wr_q;
              end
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CSUM;
              wfifo_clr_d = is_wr_q;
            end
          end
        end
        S_PEND: begin
          if (rx_done && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
          if (!sdram_busy) begin
            wr_trig_d = is_wr_q;
            rd_trig_d = !is_wr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q       <= 1'b0;
      csum_q        <= 8'd0;
      addr_q        <= '0;
      len_q         <= 8'd0;
      byte_cnt_q    <= 8'd0;
      to_cnt_q      <= '0;
      pushed_q      <= 1'b0;
      wr_trig_q     <= 1'b0;
      rd_trig_q     <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= 8'd0;
      wfifo_wr_en_q <= 1'b0;
      wfifo_data_q  <= 8'd0;
      wfifo_clr_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      drop_cnt_q    <= 8'd0;
    end else begin
      is_wr_q       <= is_wr_d;
      csum_q        <= csum_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pushed_q      <= pushed_d;
      wr_trig_q     <= wr_trig_d;
      rd_trig_q     <= rd_trig_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      wfifo_wr_en_q <= wfifo_wr_en_d;
      wfifo_data_q  <= wfifo_data_d;
      wfifo_clr_q   <= wfifo_clr_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign wr_trig     = wr_trig_q;
  assign rd_trig     = rd_trig_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign wfifo_wr_en = wfifo_wr_en_q;
  assign wfifo_data  = wfifo_data_q;
  assign wfifo_clr   = wfifo_clr_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_uart_sdram_cmd_parser.sv
// Purpose : self-checking bench for uart_sdram_cmd_parser against a frame-level reference model.
// Latency : expects every output one clk after the causing rx_done / busy release.
// Backpr. : drives sdram_busy to park frames in PEND and counts the bytes dropped there.
module tb_uart_sdram_cmd_parser;
  localparam int         AB  = 3;
  localparam int         AW  = 22;
  localparam int         ML  = 16;
  localparam int         TO  = 300;
  localparam logic [7:0] HWR = 8'h55;
  localparam logic [7:0] HRD = 8'hAA;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst, rx_done, sdram_busy;
  logic [7:0]    uart_data;
  logic          wr_trig, rd_trig, wfifo_wr_en, wfifo_clr, frame_err;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len, wfifo_data, drop_cnt;
  logic [1:0]    err_code;

  always #10 clk = ~clk;

  uart_sdram_cmd_parser #(
    .ADDR_BYTES(AB), .ADDR_W(AW), .MAX_LEN(ML), .TIMEOUT_CYC(TO), .CMD_WR(HWR), .CMD_RD(HRD)
  ) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .uart_data(uart_data), .sdram_busy(sdram_busy),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data), .wfifo_clr(wfifo_clr),
    .frame_err(frame_err), .err_code(err_code), .drop_cnt(drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // output monitor, sampled on the falling edge; counts are cumulative
  int            cyc = 0;
  int            rx_cyc = 0;
  int            busy_fall_cyc = 0;
  logic          busy_prev = 1'b0;
  bq_t           obs_push;
  int            obs_trig_n = 0, obs_err_n = 0, obs_clr_n = 0, obs_clr_err_n = 0;
  logic          obs_wr = 1'b0;
  logic [AW-1:0] obs_addr = '0;
  logic [7:0]    obs_len = 8'd0;
  logic [1:0]    obs_code = 2'd0;
  int            obs_trig_cyc = 0, obs_err_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) rx_cyc <= cyc;
    if (busy_prev && !sdram_busy) busy_fall_cyc <= cyc;
    busy_prev <= sdram_busy;
    if (wfifo_wr_en) obs_push.push_back(wfifo_data);
    if (wr_trig || rd_trig) begin
      obs_trig_n   <= obs_trig_n + int'(wr_trig) + int'(rd_trig);
      obs_wr       <= wr_trig;
      obs_addr     <= cmd_addr;
      obs_len      <= cmd_len;
      obs_trig_cyc <= cyc;
    end
    if (frame_err) begin
      obs_err_n   <= obs_err_n + 1;
      obs_code    <= err_code;
      obs_err_cyc <= cyc;
    end
    if (wfifo_clr) begin
      obs_clr_n <= obs_clr_n + 1;
      if (frame_err) obs_clr_err_n <= obs_clr_err_n + 1;
    end
  end

  // expectations that persist across frames
  int            exp_drop = 0;
  logic [1:0]    exp_last_code = 2'd0;
  logic [AW-1:0] exp_cmd_addr = '0;
  logic [7:0]    exp_cmd_len = 8'd0;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1; uart_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // builds a frame; stops after LEN when the length is illegal
  task automatic make_frame(input logic is_wr, input logic [8*AB-1:0] addr, input logic [7:0] len,
                            input logic bad_csum, output bq_t f);
    logic [7:0] x;
    f = {};
    f.push_back(is_wr ? HWR : HRD);
    for (int i = AB - 1; i >= 0; i--) f.push_back(addr[8*i +: 8]);
    f.push_back(len);
    if (len == 8'd0 || int'(len) > ML) return;
    if (is_wr) for (int j = 0; j < int'(len); j++) f.push_back(8'($urandom));
    x = 8'd0;
    foreach (f[i]) x = x ^ f[i];
    f.push_back(bad_csum ? ~x : x);
  endtask

  // reference model: derive expected outcome of a whole frame, then drive it and compare
  task automatic run_frame(input string tag, input bq_t f, input int busy_hold, input int drops,
                           input int max_gap, input int stall_at, input int stall);
    bq_t           exp_push;
    logic          exp_wr, exp_trig, exp_clr;
    logic [1:0]    exp_code;
    logic [63:0]   full;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_len, x;
    int            push0, trig0, err0, clr0, clrerr0, last_cyc;

    exp_push = {}; exp_trig = 1'b0; exp_clr = 1'b0; exp_code = 2'd0;
    exp_addr = '0; exp_len = 8'd0; full = 64'd0;
    exp_wr   = (f[0] == HWR);
    if (f[0] != HWR && f[0] != HRD) begin
      exp_code = 2'd1;
    end else begin
      for (int i = 1; i <= AB; i++) full = full * 256 + 64'(f[i]);
      exp_addr = AW'(full % (64'd1 << AW));
      exp_len  = f[AB+1];
      if (exp_len == 8'd0 || int'(exp_len) > ML) begin
        exp_code = 2'd1;
      end else begin
        if (exp_wr) for (int j = 0; j < int'(exp_len); j++) exp_push.push_back(f[AB+2+j]);
        x = 8'd0;
        for (int i = 0; i < f.size() - 1; i++) x = x ^ f[i];
        if (x == f[f.size()-1]) exp_trig = 1'b1;
        else begin exp_code = 2'd2; exp_clr = exp_wr; end
      end
    end

    push0 = obs_push.size(); trig0 = obs_trig_n; err0 = obs_err_n;
    clr0 = obs_clr_n; clrerr0 = obs_clr_err_n;
    foreach (f[i]) begin
      if (i == f.size() - 1 && busy_hold > 0) sdram_busy = 1'b1;
      send_byte(f[i]);
      if (i == stall_at) idle(stall);
      else if (i < f.size() - 1) idle($urandom_range(max_gap, 0));
    end
    last_cyc = rx_cyc;
    if (busy_hold > 0) begin
      if (exp_trig) begin
        for (int d = 0; d < drops; d++) begin
          send_byte(8'($urandom));
          idle(1);
          if (exp_drop < 255) exp_drop++;
        end
      end
      idle(busy_hold);
      sdram_busy = 1'b0;
    end
    idle(4);

    check({tag, " push_n"}, 32'(obs_push.size() - push0), 32'(exp_push.size()));
    foreach (exp_push[j])
      if (push0 + j < obs_push.size()) check({tag, " push_dat"}, 32'(obs_push[push0+j]), 32'(exp_push[j]));
    check({tag, " trig_n"}, 32'(obs_trig_n - trig0), 32'(exp_trig));
    if (exp_trig && obs_trig_n > trig0) begin
      check({tag, " trig_wr"}, 32'(obs_wr), 32'(exp_wr));
      check({tag, " trig_addr"}, 32'(obs_addr), 32'(exp_addr));
      check({tag, " trig_len"}, 32'(obs_len), 32'(exp_len));
      check({tag, " trig_cyc"}, 32'(obs_trig_cyc), 32'((busy_hold > 0 ? busy_fall_cyc : last_cyc) + 1));
      exp_cmd_addr = exp_addr;
      exp_cmd_len  = exp_len;
    end
    check({tag, " err_n"}, 32'(obs_err_n - err0), 32'(exp_code != 2'd0));
    if (exp_code != 2'd0 && obs_err_n > err0) begin
      check({tag, " err_code"}, 32'(obs_code), 32'(exp_code));
      check({tag, " err_cyc"}, 32'(obs_err_cyc), 32'(last_cyc + 1));
      exp_last_code = exp_code;
    end
    check({tag, " clr_n"}, 32'(obs_clr_n - clr0), 32'(exp_clr));
    check({tag, " clr_with_err"}, 32'(obs_clr_err_n - clrerr0), 32'(exp_clr));
    check({tag, " err_code_held"}, 32'(err_code), 32'(exp_last_code));
    check({tag, " cmd_addr_held"}, 32'(cmd_addr), 32'(exp_cmd_addr));
    check({tag, " cmd_len_held"}, 32'(cmd_len), 32'(exp_cmd_len));
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  // sends a partial frame and then stays silent long enough to expire
  task automatic run_timeout(input string tag, input bq_t f, input int exp_pushes);
    int push0, trig0, err0, clr0, clrerr0, last_cyc;
    push0 = obs_push.size(); trig0 = obs_trig_n; err0 = obs_err_n;
    clr0 = obs_clr_n; clrerr0 = obs_clr_err_n;
    foreach (f[i]) send_byte(f[i]);
    last_cyc = rx_cyc;
    idle(TO + 3);
    check({tag, " err_n"}, 32'(obs_err_n - err0), 32'd1);
    check({tag, " err_code"}, 32'(obs_code), 32'd3);
    check({tag, " err_cyc"}, 32'(obs_err_cyc), 32'(last_cyc + TO + 1));
    check({tag, " clr_n"}, 32'(obs_clr_n - clr0), 32'(exp_pushes > 0));
    check({tag, " clr_with_err"}, 32'(obs_clr_err_n - clrerr0), 32'(exp_pushes > 0));
    check({tag, " push_n"}, 32'(obs_push.size() - push0), 32'(exp_pushes));
    check({tag, " trig_n"}, 32'(obs_trig_n - trig0), 32'd0);
    exp_last_code = 2'd3;
    check({tag, " err_code_held"}, 32'(err_code), 32'd3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_trig"}, 32'(wr_trig), 32'd0);
    check({tag, " rd_trig"}, 32'(rd_trig), 32'd0);
    check({tag, " cmd_addr"}, 32'(cmd_addr), 32'd0);
    check({tag, " cmd_len"}, 32'(cmd_len), 32'd0);
    check({tag, " wfifo_wr_en"}, 32'(wfifo_wr_en), 32'd0);
    check({tag, " wfifo_data"}, 32'(wfifo_data), 32'd0);
    check({tag, " wfifo_clr"}, 32'(wfifo_clr), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " err_code"}, 32'(err_code), 32'd0);
    check({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bq_t           f;
    int            kind, busy, err0, clr0, trig0;
    logic [7:0]    len, b;
    logic [8*AB-1:0] a;

    rst = 1'b1; rx_done = 1'b0; uart_data = 8'd0; sdram_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5, 8'h5A, 8'h89};
    run_frame("t1_wr", f, 0, 0, 0, -1, 0);
    check("t1 cmd_addr_const", 32'(cmd_addr), 32'h000120);
    check("t1 cmd_len_const", 32'(cmd_len), 32'd2);

    f = '{8'hAA, 8'h00, 8'h00, 8'h10, 8'h04, 8'hBE};
    run_frame("t2_rd", f, 0, 0, 1, -1, 0);
    check("t2 cmd_addr_const", 32'(cmd_addr), 32'h000010);

    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5, 8'h5A, 8'h88};
    run_frame("t3_badcsum", f, 0, 0, 0, -1, 0);
    check("t3 err_code_const", 32'(err_code), 32'd2);

    f = '{8'h33};
    run_frame("t4_badhdr", f, 0, 0, 0, -1, 0);
    f = '{8'hAA, 8'h00, 8'h00, 8'h10, 8'h00};
    run_frame("t4_len0", f, 0, 0, 0, -1, 0);
    f = '{8'hAA, 8'h00, 8'h00, 8'h10, 8'h04, 8'hBE};
    run_frame("t4_recover", f, 0, 0, 0, -1, 0);

    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5};
    run_timeout("t5_to_data", f, 1);
    f = '{8'h55, 8'h00};
    run_timeout("t5_to_addr", f, 0);
    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5, 8'h5A};
    run_timeout("t5_to_csum_wr", f, 2);
    f = '{8'hAA, 8'h00, 8'h00, 8'h10, 8'h04};
    run_timeout("t5_to_csum_rd", f, 0);
    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5, 8'h5A, 8'h89};
    run_frame("t5_edge_accept", f, 0, 0, 0, 5, TO - 1);

    f = '{8'hAA, 8'h00, 8'h00, 8'h10, 8'h04, 8'hBE};
    run_frame("t6_busy", f, 500, 3, 0, -1, 0);
    check("t6 drop_cnt_const", 32'(drop_cnt), 32'd3);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(4, 0);
      a    = (8*AB)'($urandom);
      busy = ($urandom_range(3, 0) == 0) ? $urandom_range(20, 1) : 0;
      case (kind)
        0, 1: begin
          len = 8'($urandom_range(ML, 1));
          make_frame(kind == 0, a, len, 1'b0, f);
        end
        2: begin
          len = 8'($urandom_range(ML, 1));
          make_frame($urandom_range(1, 0) == 1, a, len, 1'b1, f);
        end
        3: begin
          len = ($urandom_range(1, 0) == 1) ? 8'd0 : 8'($urandom_range(255, ML + 1));
          make_frame($urandom_range(1, 0) == 1, a, len, 1'b0, f);
        end
        default: begin
          do b = 8'($urandom); while (b == HWR || b == HRD);
          f = {};
          f.push_back(b);
        end
      endcase
      run_frame("rnd", f, busy, $urandom_range(3, 0), 3, -1, 0);
    end

    make_frame(1'b0, 24'h3ABCDE, 8'd7, 1'b0, f);
    run_frame("sat", f, 10, 260, 0, -1, 0);
    check("sat drop_cnt_const", 32'(drop_cnt), 32'd255);

    // reset in the middle of a write frame: no trig, no clr, no later timeout
    err0 = obs_err_n; clr0 = obs_clr_n; trig0 = obs_trig_n;
    f = '{8'h55, 8'h00, 8'h01, 8'h20, 8'h02, 8'hA5};
    foreach (f[i]) send_byte(f[i]);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_all_zero("midrst");
    idle(TO + 5);
    check("midrst err_n", 32'(obs_err_n - err0), 32'd0);
    check("midrst clr_n", 32'(obs_clr_n - clr0), 32'd0);
    check("midrst trig_n", 32'(obs_trig_n - trig0), 32'd0);
    exp_drop = 0; exp_last_code = 2'd0; exp_cmd_addr = '0; exp_cmd_len = 8'd0;

    make_frame(1'b1, 24'h012345, 8'd16, 1'b0, f);
    run_frame("post_rst", f, 0, 0, 2, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
